// File: rtl/vin_cfa_sequencer.sv
// Input colour mixer sequencer: sync tracking, CFA phase counters, channel selects and
// frame-aligned mode switching. Optional statistics are built when VIN_CFA_SEQ_STATS_EN is defined.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   WAIT_VS | no frame start seen since reset; selects forced to luma (3)
//   SYNCED  | frame start seen, waiting for the first valid beat
//   ACTIVE  | valid beats flowing within a synced frame
module vin_cfa_sequencer #(
  parameter int LINE_PAIRS = 800,
  parameter int FCNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vsync,
  input  logic              in_hsync,
  input  logic              in_valid,
  input  logic [1:0]        cfg_mode,
  input  logic              cfg_req,
  output logic              cfg_ack,
  output logic [1:0]        mode_active,
  output logic [1:0]        sel_even,
  output logic [1:0]        sel_odd,
  output logic              sel_valid,
  output logic [FCNT_W-1:0] stat_frames,
  output logic              stat_line_err
);

  typedef enum logic [1:0] {WAIT_VS = 2'd0, SYNCED = 2'd1, ACTIVE = 2'd2} state_t;

  state_t     state, state_d;
  logic       hs_last, vs_last;
  logic       hs_rise, vs_rise;
  logic [1:0] cx, cy;
  logic       first_line;
  logic [1:0] pend_mode;
  logic       pend_v;
  logic [1:0] sel_even_d, sel_odd_d;

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  assign hs_rise = in_hsync & ~hs_last;
  assign vs_rise = in_vsync & ~vs_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_last <= 1'b0;
      vs_last <= 1'b0;
    end else begin
      hs_last <= in_hsync;
      vs_last <= in_vsync;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_VS;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      WAIT_VS: if (hs_rise && in_vsync) state_d = SYNCED;
      SYNCED:  if (in_valid)            state_d = ACTIVE;
      ACTIVE:  if (hs_rise && in_vsync) state_d = SYNCED;
      default:                          state_d = WAIT_VS;
    endcase
  end

  // A sync edge owns the cycle: a valid beat coinciding with hs_rise does not advance cx.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cx         <= 2'd0;
      cy         <= 2'd1;
      first_line <= 1'b1;
    end else if (hs_rise) begin
      if (in_vsync) begin
        cx         <= 2'd0;
        cy         <= 2'd1;
        first_line <= 1'b1;
      end else if (!first_line) begin
        cx <= cy;
        cy <= inc3(cy);
      end
    end else if (in_valid) begin
      first_line <= 1'b0;
      cx         <= inc3(cx);
    end
  end

  always_comb begin
    sel_even_d = 2'd3;
    sel_odd_d  = 2'd3;
    if (state != WAIT_VS) begin
      case (mode_active)
        2'd1: begin
          case (cx)
            2'd0:    begin sel_even_d = 2'd0; sel_odd_d = 2'd2; end
            2'd1:    begin sel_even_d = 2'd1; sel_odd_d = 2'd0; end
            default: begin sel_even_d = 2'd2; sel_odd_d = 2'd1; end
          endcase
        end
        2'd2: begin
          case (cx)
            2'd0:    begin sel_even_d = 2'd2; sel_odd_d = 2'd0; end
            2'd1:    begin sel_even_d = 2'd1; sel_odd_d = 2'd2; end
            default: begin sel_even_d = 2'd0; sel_odd_d = 2'd1; end
          endcase
        end
        default: begin
          sel_even_d = 2'd3;
          sel_odd_d  = 2'd3;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_even  <= 2'd3;
      sel_odd   <= 2'd3;
      sel_valid <= 1'b0;
    end else begin
      sel_valid <= in_valid;
      if (in_valid) begin
        sel_even <= sel_even_d;
        sel_odd  <= sel_odd_d;
      end
    end
  end

  // A request arriving on the vsync edge itself bypasses the pending register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_active <= 2'd0;
      pend_mode   <= 2'd0;
      pend_v      <= 1'b0;
      cfg_ack     <= 1'b0;
    end else begin
      cfg_ack <= 1'b0;
      if (vs_rise && (cfg_req || pend_v)) begin
        mode_active <= cfg_req ? cfg_mode : pend_mode;
        pend_v      <= 1'b0;
        cfg_ack     <= 1'b1;
      end else if (cfg_req) begin
        pend_mode <= cfg_mode;
        pend_v    <= 1'b1;
      end
    end
  end

`ifdef VIN_CFA_SEQ_STATS_EN
  localparam int LCNT_W = $clog2(LINE_PAIRS + 1) + 1;

  logic [LCNT_W-1:0] line_cnt;

  // Line counter saturates so an overlong line can never alias back to LINE_PAIRS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_frames   <= '0;
      stat_line_err <= 1'b0;
      line_cnt      <= '0;
    end else begin
      if (vs_rise) stat_frames <= stat_frames + FCNT_W'(1);
      if (hs_rise) begin
        if (!first_line && line_cnt != LCNT_W'(LINE_PAIRS)) stat_line_err <= 1'b1;
        line_cnt <= '0;
      end else if (in_valid && line_cnt != '1) begin
        line_cnt <= line_cnt + LCNT_W'(1);
      end
    end
  end
`else
  assign stat_frames   = '0;
  assign stat_line_err = 1'b0;
`endif

endmodule
